instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch unit: the requesting end of the 16-bit program-flash read port and the producer of the instruction word fed to the decompressor. It issues halfword reads to flash, buffers returned halfwords, assembles aligned 16- or 32-bit instructions with their byte PC, and presents them downstream under a valid/ready handshake. It supports redirection to an arbitrary halfword-aligned PC, for jumps and branches, by flushing its buffer.

## Interface
- PMEM_WIDTH, 10, flash halfword-address width; PC width is PMEM_WIDTH+1 bits (byte address).
- EXTENSION_C, 1, 1 = 16-bit compressed instructions allowed; 0 = every instruction is treated as 32-bit.
- RESET_PC, 0, byte PC fetched after reset; bit 0 ignored.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- pmem_ce  out  1  flash read enable.
- pmem_a  out  PMEM_WIDTH  flash halfword address.
- pmem_d  in  16  flash read data; valid the cycle after pmem_ce=1.
- instr_valid  out  1  instr/instr_pc/instr_is_32bit hold a complete instruction.
- instr_ready  in  1  downstream accepts; transfer = valid & ready.
- instr  out  32  instruction; 16-bit instructions are zero-extended, {16'h0, hw}.
- instr_is_32bit  out  1  1 when instr[1:0]==2'b11 or EXTENSION_C=0.
- instr_pc  out  PMEM_WIDTH+1  byte PC of instr.
- redirect  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  PMEM_WIDTH+1  new byte PC; bit 0 ignored.

## Operation
- State: halfword buffer of 3 entries (buf0 oldest), count 0..3, inflight bit, discard bit, fetch address fa, output PC pc.
- Issue rule: pmem_ce = !rst & !redirect & (count + inflight <= 2). pmem_a = fa. On issue: fa <= fa+1, which wraps modulo 2^PMEM_WIDTH; inflight <= 1. Otherwise inflight <= 0.
- Return: when inflight=1 and discard=0, pmem_d is appended at buf[count - consumed]. When discard=1, pmem_d is dropped and discard is cleared.
- Length decode: len32 = (EXTENSION_C==0) | (buf0[1:0]==2'b11).
- Valid: instr_valid = (count>=1 & !len32) | (count>=2 & len32). instr = len32 ? {buf1,buf0} : {16'h0,buf0}. Outputs must hold stable while valid & !ready.
- Consume on valid & ready: shift the buffer by 1 (16-bit) or 2 (32-bit); pc <= pc+2 or pc+4, which wraps at PC width. Consume and append in the same cycle are both applied (count' = count - consumed + appended).
- Redirect (priority over all): count <= 0; pc <= {redirect_pc[PMEM_WIDTH:1],1'b0}; fa <= redirect_pc[PMEM_WIDTH:1]; discard <= inflight. A transfer in the redirect cycle is visible to downstream but has no effect on fetch state.
- Reset: count=0, inflight=0, discard=0, buffer=0, fa=RESET_PC[PMEM_WIDTH:1], pc={RESET_PC[PMEM_WIDTH:1],1'b0}. Reset mid-operation abandons any in-flight read; the flash response in the cycle after reset is ignored (inflight=0).
- Reset output values: pmem_ce=0, pmem_a=RESET_PC[PMEM_WIDTH:1], instr_valid=0, instr=0, instr_is_32bit=EXTENSION_C?0:1, instr_pc=RESET_PC & ~1.
- Full: count+inflight=3 means no issue. Empty: instr_valid=0 and downstream waits. No underflow or overflow is possible by construction.

## Timing
- Flash latency: 1 cycle (address at cycle n, data at n+1, captured at end of n+1).
- After rst deasserts in cycle 0: pmem_ce=1 in cycles 0,1,2. A 16-bit first instruction is valid in cycle 2. A 32-bit first instruction is valid in cycle 3.
- Redirect asserted in cycle n: pmem_ce=0 in n, new address in n+1, data in n+2. A 16-bit target is valid in n+3; a 32-bit target in n+4.
- Sustained throughput: one halfword per cycle, i.e. one 16-bit instruction per cycle or one 32-bit instruction per 2 cycles, with ready held high.
- All outputs are combinational from registers only, except pmem_ce, which depends combinationally on redirect.

## Test plan
- Reset, flash[0]=16'h4501 (C insn), flash[1..2]=32'h00A00093, ready=1 -> cycle 2: instr=32'h00004501, pc=0, is_32bit=0; cycle 3 or later: instr=32'h00A00093, pc=2, is_32bit=1.
- Hold ready=0 for 10 cycles after first valid -> instr/pc stable; pmem_ce drops once count+inflight=3; no halfword lost when ready returns.
- Redirect to 0x10 while a read is in flight -> stale pmem_d dropped; pmem_a=8 in cycle n+1; the first valid has pc=0x10 with flash[8] contents.
- EXTENSION_C=0, flash[0]=16'h0001 -> treated as 32-bit: instr={flash[1],16'h0001}, is_32bit=1, pc advances by 4.
- Fetch across the top of memory (PMEM_WIDTH=4, RESET_PC=0x1E, 32-bit insn) -> halfwords read from addresses 15 then 0; next pc=0x02 (wrap).
- Assert rst for 1 cycle mid-stream with valid=1 -> next cycle valid=0, pc=RESET_PC; refetch starts at RESET_PC and matches the cold-reset sequence.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues halfword reads to program flash, buffers the
// returned halfwords and presents aligned 16/32-bit instructions with their PC.
module instr_fetch #(
    parameter int PMEM_WIDTH  = 10,
    parameter int EXTENSION_C = 1,
    parameter int RESET_PC    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  pmem_ce,
    output logic [PMEM_WIDTH-1:0] pmem_a,
    input  logic [15:0]           pmem_d,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [31:0]           instr,
    output logic                  instr_is_32bit,
    output logic [PMEM_WIDTH:0]   instr_pc,
    input  logic                  redirect,
    input  logic [PMEM_WIDTH:0]   redirect_pc
);

    localparam logic [31:0]           RESET_PC_W = RESET_PC;
    localparam logic [PMEM_WIDTH-1:0] FA_RST     = RESET_PC_W[PMEM_WIDTH:1];
    localparam logic [PMEM_WIDTH-1:0] FA_ONE     = {{(PMEM_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PMEM_WIDTH:0]   PC_TWO     = {{(PMEM_WIDTH-1){1'b0}}, 2'b10};
    localparam logic [PMEM_WIDTH:0]   PC_FOUR    = {{(PMEM_WIDTH-2){1'b0}}, 3'b100};

    logic [15:0]           buf0_q, buf1_q, buf2_q;
    logic [15:0]           buf0_d, buf1_d, buf2_d;
    logic [1:0]            count_q, count_d;
    logic                  inflight_q, inflight_d;
    logic                  discard_q, discard_d;
    logic [PMEM_WIDTH-1:0] fa_q, fa_d;
    logic [PMEM_WIDTH:0]   pc_q, pc_d;

    logic                  len32;
    logic                  fire;
    logic                  issue;
    logic                  append;
    logic [1:0]            consumed;
    logic [1:0]            slot;
    logic [2:0]            occ;

    assign len32       = (EXTENSION_C == 0) || (buf0_q[1:0] == 2'b11);
    assign instr_valid = len32 ? (count_q >= 2'd2) : (count_q >= 2'd1);
    assign fire        = instr_valid && instr_ready;
    assign consumed    = !fire ? 2'd0 : (len32 ? 2'd2 : 2'd1);
    assign occ         = {1'b0, count_q} + {2'b00, inflight_q};
    // The read returning in a redirect cycle belongs to the old stream; it is
    // dropped because the buffer restarts empty, and discard covers the cycle after.
    assign issue       = !rst && !redirect && (occ <= 3'd2);
    assign append      = inflight_q && !discard_q;
    assign slot        = count_q - consumed;

    assign pmem_ce        = issue;
    assign pmem_a         = fa_q;
    assign instr          = len32 ? {buf1_q, buf0_q} : {16'h0000, buf0_q};
    assign instr_is_32bit = len32;
    assign instr_pc       = pc_q;

    always_comb begin
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        buf2_d     = buf2_q;
        count_d    = count_q - consumed + {1'b0, append};
        inflight_d = issue;
        discard_d  = 1'b0;
        fa_d       = issue ? fa_q + FA_ONE : fa_q;
        pc_d       = pc_q;

        case (consumed)
            2'd1: begin
                buf0_d = buf1_q;
                buf1_d = buf2_q;
                buf2_d = 16'h0000;
            end
            2'd2: begin
                buf0_d = buf2_q;
                buf1_d = 16'h0000;
                buf2_d = 16'h0000;
            end
            default: ;
        endcase

        if (append) begin
            case (slot)
                2'd0:    buf0_d = pmem_d;
                2'd1:    buf1_d = pmem_d;
                default: buf2_d = pmem_d;
            endcase
        end

        if (fire) begin
            pc_d = pc_q + (len32 ? PC_FOUR : PC_TWO);
        end

        if (redirect) begin
            buf0_d    = buf0_q;
            buf1_d    = buf1_q;
            buf2_d    = buf2_q;
            count_d   = 2'd0;
            pc_d      = {redirect_pc[PMEM_WIDTH:1], 1'b0};
            fa_d      = redirect_pc[PMEM_WIDTH:1];
            discard_d = inflight_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf0_q     <= 16'h0000;
            buf1_q     <= 16'h0000;
            buf2_q     <= 16'h0000;
            count_q    <= 2'd0;
            inflight_q <= 1'b0;
            discard_q  <= 1'b0;
            fa_q       <= FA_RST;
            pc_q       <= {FA_RST, 1'b0};
        end else begin
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            buf2_q     <= buf2_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            fa_q       <= fa_d;
            pc_q       <= pc_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: three configurations (default, no compressed, 4-bit
// flash wrapping) checked against a memory-walking scoreboard plus timing points.
module tb_instr_fetch;

    typedef struct {
        logic [31:0] instr;
        logic [10:0] pc;
        logic        is32;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    logic [15:0] mem0[1024];
    logic [15:0] mem1[1024];
    logic [15:0] mem2[16];

    // default configuration
    logic        rst0, rdy0, redir0, ce0, v0, is0;
    logic [10:0] rpc0, pc0;
    logic [9:0]  a0;
    logic [15:0] d0;
    logic [31:0] ins0;

    // no compressed instructions
    logic        rst1, rdy1, redir1, ce1, v1, is1;
    logic [10:0] rpc1, pc1;
    logic [9:0]  a1;
    logic [15:0] d1;
    logic [31:0] ins1;

    // tiny flash, reset PC near the top
    logic        rst2, rdy2, redir2, ce2, v2, is2;
    logic [4:0]  rpc2, pc2;
    logic [3:0]  a2;
    logic [15:0] d2;
    logic [31:0] ins2;

    instr_fetch #(.PMEM_WIDTH(10), .EXTENSION_C(1), .RESET_PC(0)) u0 (
        .clk(clk), .rst(rst0), .pmem_ce(ce0), .pmem_a(a0), .pmem_d(d0),
        .instr_valid(v0), .instr_ready(rdy0), .instr(ins0), .instr_is_32bit(is0),
        .instr_pc(pc0), .redirect(redir0), .redirect_pc(rpc0));

    instr_fetch #(.PMEM_WIDTH(10), .EXTENSION_C(0), .RESET_PC(0)) u1 (
        .clk(clk), .rst(rst1), .pmem_ce(ce1), .pmem_a(a1), .pmem_d(d1),
        .instr_valid(v1), .instr_ready(rdy1), .instr(ins1), .instr_is_32bit(is1),
        .instr_pc(pc1), .redirect(redir1), .redirect_pc(rpc1));

    instr_fetch #(.PMEM_WIDTH(4), .EXTENSION_C(1), .RESET_PC(30)) u2 (
        .clk(clk), .rst(rst2), .pmem_ce(ce2), .pmem_a(a2), .pmem_d(d2),
        .instr_valid(v2), .instr_ready(rdy2), .instr(ins2), .instr_is_32bit(is2),
        .instr_pc(pc2), .redirect(redir2), .redirect_pc(rpc2));

    // one-cycle-latency flash; garbage when not enabled
    always @(posedge clk) begin
        d0 <= ce0 ? mem0[a0] : 16'hDEAD;
        d1 <= ce1 ? mem1[a1] : 16'hDEAD;
        d2 <= ce2 ? mem2[a2] : 16'hDEAD;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] rd(input int k, input int a);
        case (k)
            0:       return mem0[a];
            1:       return mem1[a];
            default: return mem2[a];
        endcase
    endfunction

    // walk the flash image from a start PC and queue the instruction stream
    task automatic push_seq(input int k, input int start, input int n);
        int aw, mask, hpc;
        logic [15:0] lo, hi;
        exp_t e;
        aw   = (k == 2) ? 4 : 10;
        mask = (1 << aw) - 1;
        hpc  = (start >> 1) & mask;
        for (int i = 0; i < n; i++) begin
            lo   = rd(k, hpc);
            e.pc = 11'(hpc * 2);
            if (k == 1 || lo[1:0] == 2'b11) begin
                hi      = rd(k, (hpc + 1) & mask);
                e.instr = {hi, lo};
                e.is32  = 1'b1;
                hpc     = (hpc + 2) & mask;
            end else begin
                e.instr = {16'h0000, lo};
                e.is32  = 1'b0;
                hpc     = (hpc + 1) & mask;
            end
            case (k)
                0:       q0.push_back(e);
                1:       q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
    endtask

    task automatic sb(input int k, input logic [31:0] ins, input logic [10:0] pc, input logic is32);
        exp_t e;
        int   sz;
        sz = (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
        total++;
        assert (sz != 0) else begin
            bad++;
            $error("FAIL sb%0d_unexpected: got pc %h instr %h expected no transfer", k, pc, ins);
        end
        if (sz != 0) begin
            case (k)
                0:       e = q0.pop_front();
                1:       e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
            chk($sformatf("sb%0d_instr", k), ins, e.instr);
            chk($sformatf("sb%0d_pc", k), {21'h0, pc}, {21'h0, e.pc});
            chk($sformatf("sb%0d_is32", k), {31'h0, is32}, {31'h0, e.is32});
        end
    endtask

    task automatic to_neg();
        @(negedge clk);
        if ((v0 & rdy0) === 1'b1) sb(0, ins0, pc0, is0);
        if ((v1 & rdy1) === 1'b1) sb(1, ins1, pc1, is1);
        if ((v2 & rdy2) === 1'b1) sb(2, ins2, {6'h00, pc2}, is2);
    endtask

    task automatic to_next();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            to_neg();
            to_next();
        end
    endtask

    // leaves the bench at the negedge where u0 shows valid (or budget expires)
    task automatic wait_v0(input int budget);
        int n;
        n = 0;
        to_neg();
        while (v0 !== 1'b1 && n < budget) begin
            to_next();
            to_neg();
            n++;
        end
        chk("wait_valid", {31'h0, v0}, 32'h1);
    endtask

    task automatic wait_ce0(input int budget);
        int n;
        n = 0;
        to_neg();
        while (ce0 !== 1'b1 && n < budget) begin
            to_next();
            to_neg();
            n++;
        end
        chk("wait_ce", {31'h0, ce0}, 32'h1);
    endtask

    initial begin
        logic [31:0] held_ins;
        logic [10:0] held_pc;

        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        rdy0 = 1'b1; rdy1 = 1'b1; rdy2 = 1'b1;
        redir0 = 1'b0; redir1 = 1'b0; redir2 = 1'b0;
        rpc0 = 11'h0; rpc1 = 11'h0; rpc2 = 5'h0;
        for (int i = 0; i < 1024; i++) begin
            mem0[i] = 16'($urandom);
            mem1[i] = 16'($urandom);
        end
        for (int i = 0; i < 16; i++) mem2[i] = 16'($urandom);
        mem0[0] = 16'h4501; mem0[1] = 16'h0093; mem0[2] = 16'h00A0;
        mem0[8] = 16'h1234;
        mem0[32] = 16'h0513; mem0[33] = 16'h0000;
        mem1[0] = 16'h0001; mem1[1] = 16'hABCD;
        mem2[15] = 16'h0093; mem2[0] = 16'h00A0;

        repeat (2) @(posedge clk);
        #1;

        // reset state of all three instances
        to_neg();
        chk("rst_ce0", {31'h0, ce0}, 32'h0);
        chk("rst_a0", {22'h0, a0}, 32'h0);
        chk("rst_v0", {31'h0, v0}, 32'h0);
        chk("rst_instr0", ins0, 32'h0);
        chk("rst_is32_0", {31'h0, is0}, 32'h0);
        chk("rst_pc0", {21'h0, pc0}, 32'h0);
        chk("rst_is32_1", {31'h0, is1}, 32'h1);
        chk("rst_v1", {31'h0, v1}, 32'h0);
        chk("rst_a2", {28'h0, a2}, 32'hF);
        chk("rst_pc2", {27'h0, pc2}, 32'h1E);
        chk("rst_ce2", {31'h0, ce2}, 32'h0);
        to_next();

        // cold start, 16-bit then 32-bit
        push_seq(0, 0, 200);
        rst0 = 1'b0;
        to_neg();
        chk("c0_ce", {31'h0, ce0}, 32'h1);
        chk("c0_a", {22'h0, a0}, 32'h0);
        chk("c0_v", {31'h0, v0}, 32'h0);
        to_next();
        to_neg();
        chk("c1_ce", {31'h0, ce0}, 32'h1);
        chk("c1_a", {22'h0, a0}, 32'h1);
        chk("c1_v", {31'h0, v0}, 32'h0);
        to_next();
        to_neg();
        chk("c2_ce", {31'h0, ce0}, 32'h1);
        chk("c2_v", {31'h0, v0}, 32'h1);
        chk("c2_instr", ins0, 32'h00004501);
        to_next();
        to_neg();
        chk("c3_v", {31'h0, v0}, 32'h0);
        to_next();
        to_neg();
        chk("c4_v", {31'h0, v0}, 32'h1);
        chk("c4_instr", ins0, 32'h00A00093);
        chk("c4_pc", {21'h0, pc0}, 32'h2);
        to_next();
        cyc(30);

        // redirect to a 16-bit target while a read is in flight
        wait_ce0(20);
        to_next();
        redir0 = 1'b1;
        rpc0   = 11'h010;
        to_neg();
        chk("rd_n_ce", {31'h0, ce0}, 32'h0);
        to_next();
        redir0 = 1'b0;
        q0.delete();
        push_seq(0, 16, 200);
        to_neg();
        chk("rd_n1_ce", {31'h0, ce0}, 32'h1);
        chk("rd_n1_a", {22'h0, a0}, 32'h8);
        chk("rd_n1_v", {31'h0, v0}, 32'h0);
        to_next();
        to_neg();
        chk("rd_n2_v", {31'h0, v0}, 32'h0);
        to_next();
        to_neg();
        chk("rd_n3_v", {31'h0, v0}, 32'h1);
        chk("rd_n3_pc", {21'h0, pc0}, 32'h10);
        to_next();
        cyc(10);

        // redirect to an odd PC holding a 32-bit instruction
        redir0 = 1'b1;
        rpc0   = 11'h041;
        to_neg();
        chk("rd32_n_ce", {31'h0, ce0}, 32'h0);
        to_next();
        redir0 = 1'b0;
        q0.delete();
        push_seq(0, 64, 200);
        to_neg();
        chk("rd32_n1_a", {22'h0, a0}, 32'h20);
        to_next();
        cyc(1);
        to_neg();
        chk("rd32_n3_v", {31'h0, v0}, 32'h0);
        to_next();
        to_neg();
        chk("rd32_n4_v", {31'h0, v0}, 32'h1);
        chk("rd32_n4_pc", {21'h0, pc0}, 32'h40);
        chk("rd32_n4_instr", ins0, 32'h00000513);
        to_next();
        cyc(10);

        // downstream stall: outputs hold and fetch stops when full
        rdy0 = 1'b0;
        wait_v0(20);
        held_ins = ins0;
        held_pc  = pc0;
        to_next();
        for (int i = 0; i < 10; i++) begin
            to_neg();
            chk("hold_v", {31'h0, v0}, 32'h1);
            chk("hold_instr", ins0, held_ins);
            chk("hold_pc", {21'h0, pc0}, {21'h0, held_pc});
            if (i == 9) chk("hold_ce", {31'h0, ce0}, 32'h0);
            to_next();
        end
        rdy0 = 1'b1;
        cyc(20);

        // random backpressure
        for (int i = 0; i < 60; i++) begin
            rdy0 = 1'($urandom_range(0, 1));
            cyc(1);
        end
        rdy0 = 1'b1;

        // one-cycle reset while an instruction is valid
        wait_v0(20);
        to_next();
        rst0 = 1'b1;
        to_neg();
        chk("mrst_ce", {31'h0, ce0}, 32'h0);
        to_next();
        rst0 = 1'b0;
        q0.delete();
        push_seq(0, 0, 200);
        to_neg();
        chk("mrst_v", {31'h0, v0}, 32'h0);
        chk("mrst_pc", {21'h0, pc0}, 32'h0);
        chk("mrst_a", {22'h0, a0}, 32'h0);
        chk("mrst_ce1", {31'h0, ce0}, 32'h1);
        to_next();
        cyc(1);
        to_neg();
        chk("mrst_c2_v", {31'h0, v0}, 32'h1);
        chk("mrst_c2_instr", ins0, 32'h00004501);
        to_next();
        cyc(20);

        // no compressed support: everything is 32-bit
        push_seq(1, 0, 200);
        rst1 = 1'b0;
        cyc(2);
        to_neg();
        chk("nc_c2_v", {31'h0, v1}, 32'h0);
        to_next();
        to_neg();
        chk("nc_c3_v", {31'h0, v1}, 32'h1);
        chk("nc_c3_instr", ins1, 32'hABCD0001);
        chk("nc_c3_is32", {31'h0, is1}, 32'h1);
        to_next();
        cyc(20);

        // fetch across the top of a 16-halfword flash
        push_seq(2, 30, 200);
        rst2 = 1'b0;
        to_neg();
        chk("wr_c0_a", {28'h0, a2}, 32'hF);
        chk("wr_c0_ce", {31'h0, ce2}, 32'h1);
        to_next();
        to_neg();
        chk("wr_c1_a", {28'h0, a2}, 32'h0);
        to_next();
        to_neg();
        chk("wr_c2_v", {31'h0, v2}, 32'h0);
        to_next();
        to_neg();
        chk("wr_c3_v", {31'h0, v2}, 32'h1);
        chk("wr_c3_instr", ins2, 32'h00A00093);
        chk("wr_c3_pc", {27'h0, pc2}, 32'h1E);
        to_next();
        to_neg();
        chk("wr_next_pc", {27'h0, pc2}, 32'h02);
        to_next();
        cyc(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
